data_bus_arbiter: RTL and testbench

DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

---
 rtl/data_bus_arbiter_pkg.sv | 18 +
 rtl/rr_arbiter2.sv | 34 +++
 rtl/data_bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_data_bus_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_arbiter_pkg.sv
// Shared types and constants for the two-requester data bus arbiter:
// FSM state encoding, transfer direction codes and bus widths.
package data_bus_arbiter_pkg;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin select with its last-grant register; the grant is
// only committed to history when the caller accepts it with 'take'.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic grant,
    output logic any_req
);

    logic last_grant;

    // NOTE: every output of a combinational block is assigned on every path,
    // otherwise synthesis infers a latch to hold the missing case.
    always_comb begin
        any_req = req0 | req1;
        grant   = req1;
        if (req0 && req1) begin
            grant = ~last_grant;
        end
    end

    // Reset to 1 so that requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (take && any_req) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Arbitrates the core data port (m0) and a DMA/loader (m1) onto one memory
// bus. Define DATA_ARB_LOCK_EN to add m0_lock/m1_lock grant locking.
module data_bus_arbiter
    import data_bus_arbiter_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                m0_req,
    input  logic                m0_rw,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_ack,
    input  logic                m1_req,
    input  logic                m1_rw,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_ack,
`ifdef DATA_ARB_LOCK_EN
    input  logic                m0_lock,
    input  logic                m1_lock,
`endif
    output logic                bus_cs,
    output logic                bus_rw,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                bus_owner
);

    localparam logic [2:0] LAST_CNT = 3'(RD_LATENCY - 1);

    state_t              state, state_next;
    logic                owner;
    logic                op_rw;
    logic [ADDR_W-1:0]   op_addr;
    logic [DATA_W-1:0]   op_wdata;
    logic [DATA_W-1:0]   rdata_q;
    logic [2:0]          cnt;

    logic                req0_v, req1_v;
    logic                grant, any_req;
    logic                idle, issue, done;

    assign idle  = (state == IDLE);
    assign issue = (state == ISSUE);
    assign done  = (state == DONE);

`ifdef DATA_ARB_LOCK_EN
    logic lock_hold;

    // While a lock is held only the current owner may compete.
    assign req0_v = m0_req & ~(lock_hold & owner);
    assign req1_v = m1_req & ~(lock_hold & ~owner);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_hold <= 1'b0;
        end else if (done) begin
            lock_hold <= owner ? m1_lock : m0_lock;
        end
    end
`else
    assign req0_v = m0_req;
    assign req1_v = m1_req;
`endif

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0_v),
        .req1    (req1_v),
        .take    (idle),
        .grant   (grant),
        .any_req (any_req)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (any_req) state_next = ISSUE;
            ISSUE:   state_next = (op_rw == RW_WRITE) ? DONE : WAIT;
            WAIT:    if (cnt == LAST_CNT) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: all datapath registers are reset, so the bus and read-data
    // outputs come up as zero instead of whatever powered up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= 1'b0;
            op_rw    <= RW_READ;
            op_addr  <= '0;
            op_wdata <= '0;
            rdata_q  <= '0;
            cnt      <= 3'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner    <= grant;
                        op_rw    <= grant ? m1_rw    : m0_rw;
                        op_addr  <= grant ? m1_addr  : m0_addr;
                        op_wdata <= grant ? m1_wdata : m0_wdata;
                        rdata_q  <= '0;
                        cnt      <= 3'd0;
                    end
                end
                WAIT: begin
                    if (cnt == LAST_CNT) begin
                        rdata_q <= bus_rdata;
                        cnt     <= 3'd0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus outputs are qualified by ISSUE so a reset drops them immediately.
    assign bus_cs    = issue;
    assign bus_rw    = issue & op_rw;
    assign bus_addr  = issue ? op_addr  : '0;
    assign bus_wdata = issue ? op_wdata : '0;
    assign bus_owner = owner;

    assign m0_ack   = done & ~owner;
    assign m1_ack   = done &  owner;
    assign m0_rdata = m0_ack ? rdata_q : '0;
    assign m1_rdata = m1_ack ? rdata_q : '0;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter: transaction-level timeline model,
// a latency-accurate memory, directed scenarios and randomized traffic.
module tb_data_bus_arbiter;

    localparam int RD_LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_rw, m1_req, m1_rw;
    logic [29:0] m0_addr, m1_addr, bus_addr;
    logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack;
    logic        bus_cs, bus_rw, bus_owner;
    logic [31:0] bus_wdata, bus_rdata;
`ifdef DATA_ARB_LOCK_EN
    logic        m0_lock, m1_lock;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_bus_arbiter #(.RD_LATENCY(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack),
`ifdef DATA_ARB_LOCK_EN
        .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
        .bus_cs(bus_cs), .bus_rw(bus_rw), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_owner(bus_owner)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Transfer timeline model: k counts cycles since the sampling IDLE cycle.
    int          k = 0, dlen = 0;
    bit          mo = 0, last_g = 1, lk_hold = 0;
    logic        w_rw;
    logic [29:0] w_addr;
    logic [31:0] w_wdata, w_rd;
    logic [31:0] mmem [0:31];
    bit          ea0 = 0, ea1 = 0;

    // Memory seen by the bus: read data valid only RD_LAT cycles after strobe.
    logic [31:0] mem [0:31];
    bit          rd_pend = 0;
    int          rd_cnt = 0;
    logic [31:0] rd_val;

    task automatic model_reset();
        k = 0; mo = 0; last_g = 1; lk_hold = 0;
    endtask

    task automatic model_step();
        bit r0, r1, win;
        if (k == 0) begin
            r0 = m0_req; r1 = m1_req;
            if (lk_hold) begin
                if (mo) r0 = 0; else r1 = 0;
            end
            if (r0 || r1) begin
                win     = (r0 && r1) ? !last_g : r1;
                last_g  = win;
                mo      = win;
                w_rw    = win ? m1_rw    : m0_rw;
                w_addr  = win ? m1_addr  : m0_addr;
                w_wdata = win ? m1_wdata : m0_wdata;
                dlen    = w_rw ? 2 : 2 + RD_LAT;
                w_rd    = w_rw ? 32'h0 : mmem[w_addr[4:0]];
                if (w_rw) mmem[w_addr[4:0]] = w_wdata;
                k = 1;
            end
        end else if (k == dlen) begin
`ifdef DATA_ARB_LOCK_EN
            lk_hold = mo ? m1_lock : m0_lock;
`endif
            k = 0;
        end else begin
            k++;
        end
    endtask

    task automatic compare();
        bit in_done;
        in_done = (k != 0) && (k == dlen);
        ea0 = in_done && !mo;
        ea1 = in_done && mo;
        check("bus_cs", 32'(bus_cs), 32'(k == 1));
        if (k == 1) begin
            check("bus_rw", 32'(bus_rw), 32'(w_rw));
            check("bus_addr", 32'(bus_addr), 32'(w_addr));
            check("bus_wdata", bus_wdata, w_wdata);
        end
        check("bus_owner", 32'(bus_owner), 32'(mo));
        check("m0_ack", 32'(m0_ack), 32'(ea0));
        check("m1_ack", 32'(m1_ack), 32'(ea1));
        if (in_done) begin
            check("m0_rdata", m0_rdata, ea0 ? w_rd : 32'h0);
            check("m1_rdata", m1_rdata, ea1 ? w_rd : 32'h0);
        end
    endtask

    task automatic env_mem();
        bit valid;
        if (!rst_n) rd_pend = 0;
        if (rd_pend) rd_cnt--;
        if (bus_cs && rst_n) begin
            if (bus_rw) mem[bus_addr[4:0]] = bus_wdata;
            else begin
                rd_pend = 1; rd_cnt = RD_LAT; rd_val = mem[bus_addr[4:0]];
            end
        end
        valid = rd_pend && (rd_cnt == 0);
        bus_rdata = valid ? rd_val : $urandom();
        if (valid) rd_pend = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] = 32'h0; mmem[i] = 32'h0;
        end
        bus_rdata = 32'h0;
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset(); else model_step();
            @(negedge clk);
            if (!rst_n) model_reset();
            compare();
            env_mem();
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic req, input logic rw,
                         input logic [29:0] addr, input logic [31:0] wdata);
        if (i == 0) begin
            m0_req = req; m0_rw = rw; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_rw = rw; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          n, found;
        logic [3:0]  owners;
        bit          p0, p1;
        rst_n = 1'b0;
        drive(0, 0, 0, 30'h0, 32'h0);
        drive(1, 0, 0, 30'h0, 32'h0);
`ifdef DATA_ARB_LOCK_EN
        m0_lock = 1'b0; m1_lock = 1'b0;
`endif
        repeat (3) tick();
        check("rst_bus_cs", 32'(bus_cs), 32'h0);
        check("rst_bus_owner", 32'(bus_owner), 32'h0);
        check("rst_bus_addr", 32'(bus_addr), 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_acks", 32'({m0_ack, m1_ack}), 32'h0);
        check("rst_rdata", m0_rdata | m1_rdata, 32'h0);
        rst_n = 1'b1;
        tick();

        // m0 write: strobe in cycle 1 only, ack in cycle 2.
        drive(0, 1, 1, 30'h0000010, 32'hDEADBEEF);
        tick();
        check("wr_cs_c1", 32'(bus_cs), 32'h1);
        check("wr_addr_c1", 32'(bus_addr), 32'h10);
        check("wr_ack_c1", 32'(m0_ack), 32'h0);
        tick();
        check("wr_ack_c2", 32'(m0_ack), 32'h1);
        check("wr_cs_c2", 32'(bus_cs), 32'h0);
        m0_req = 1'b0;
        check("wr_mem", mem[16], 32'hDEADBEEF);
        tick();

        // m1 read of the same word: ack in cycle N+5 with the written data.
        drive(1, 1, 0, 30'h0000010, 32'h0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("rd_ack_c%0d", i), 32'(m1_ack), 32'(i == 5));
            if (i == 5) check("rd_data", m1_rdata, 32'hDEADBEEF);
        end
        m1_req = 1'b0;
        tick();

        // Continuous contention: grants alternate starting with m0.
        drive(0, 1, 1, 30'h3, 32'h1111_0003);
        drive(1, 1, 0, 30'h3, 32'h0);
        n = 0; owners = '0;
        for (int c = 0; c < 80 && n < 4; c++) begin
            tick();
            if (bus_cs) begin
                owners[n] = bus_owner;
                n++;
            end
        end
        check("rr_grants_seen", 32'(n), 32'd4);
        check("rr_order", 32'(owners), 32'b1010);
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            tick();
            if (m1_ack) found = 1;
        end
        check("rr_last_ack", 32'(found), 32'h1);
        drive(0, 0, 0, 30'h0, 32'h0);
        drive(1, 0, 0, 30'h0, 32'h0);
        tick();

        // Reset during WAIT aborts the read; the retried request completes.
        drive(0, 1, 0, 30'h5, 32'h0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_cs", 32'(bus_cs), 32'h0);
        check("abort_acks", 32'({m0_ack, m1_ack}), 32'h0);
        tick();
        tick();
        check("abort_no_ack", 32'({m0_ack, m1_ack}), 32'h0);
        rst_n = 1'b1;
        found = 0;
        for (int i = 1; i <= 10 && found == 0; i++) begin
            tick();
            if (m0_ack) found = i;
        end
        check("retry_ack_cycle", 32'(found), 32'd5);
        m0_req = 1'b0;
        tick();

`ifdef DATA_ARB_LOCK_EN
        // m1 locks for its first two transfers: three m1 grants, then m0.
        drive(1, 1, 1, 30'h7, 32'hA5A5_0001);
        m1_lock = 1'b1;
        tick();
        drive(0, 1, 0, 30'h7, 32'h0);
        n = 0; owners = '0; found = 0; p1 = 0;
        for (int c = 0; c < 100 && n < 4; c++) begin
            tick();
            if (p1) begin
                p1 = 0;
                if (found == 3) m1_req = 1'b0;
                else begin
                    m1_wdata = m1_wdata + 32'd1;
                    m1_lock  = (found < 2);
                end
            end
            if (bus_cs) begin
                owners[n] = bus_owner;
                n++;
            end
            if (m1_ack) begin
                found++;
                p1 = 1;
            end
        end
        check("lock_grants_seen", 32'(n), 32'd4);
        check("lock_order", 32'(owners), 32'b0111);
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            tick();
            if (m0_ack) found = 1;
        end
        check("lock_m0_ack", 32'(found), 32'h1);
        drive(0, 0, 0, 30'h0, 32'h0);
        drive(1, 0, 0, 30'h0, 32'h0);
        m1_lock = 1'b0;
        tick();
`endif

        // Randomized traffic; operands change only after an ack or while idle.
        p0 = 0; p1 = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                bit pend, rq;
                pend = (i == 0) ? p0 : p1;
                rq   = (i == 0) ? m0_req : m1_req;
                if (pend || !rq) begin
                    drive(i, ($urandom_range(0, 9) < 6), $urandom_range(0, 1),
                          30'($urandom_range(0, 31)), $urandom());
                end
            end
            p0 = ea0;
            p1 = ea1;
        end
        drive(0, 0, 0, 30'h0, 32'h0);
        drive(1, 0, 0, 30'h0, 32'h0);
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
